platform_onchip_memory_tester: RTL and testbench
================================================

// Module: platform_onchip_memory_tester
// PURPOSE
//  Avalon-MM master that drives the 32-bit x 8192-word on-chip memory slave as a self-test/scrub
//  engine. FILL writes a generated pattern over a word range; CHECK reads it back pipelined,
//  compares against the same pattern, counts mismatches and captures the first bad address.
//  Sits beside the Nios II data master on the platform interconnect; started/polled by a CSR block.
// PARAMETERS
//  ADDR_W       13   word-address width of target memory (depth = 2**ADDR_W)
//  DATA_W       32   data width; byteenable = all ones, DATA_W/8 bits
//  MAX_PENDING  4    max outstanding reads in CHECK (1..15)
//  ERR_W        16   width of mismatch counter (saturating)
// PORTS
//  clk              in   1         system clock
//  reset_n          in   1         synchronous active-low reset
//  cmd_start        in   1         1-cycle start pulse; sampled only in IDLE
//  cmd_mode         in   1         0=FILL, 1=CHECK
//  cmd_base         in   ADDR_W    first word address
//  cmd_len          in   ADDR_W+1  word count, 0..2**ADDR_W
//  cmd_seed         in   DATA_W    pattern seed
//  busy             out  1         high from cycle after accepted start until done
//  done             out  1         1-cycle pulse when command completes
//  err_count        out  ERR_W     CHECK mismatches, saturates at all ones
//  first_err_valid  out  1         a mismatch has been captured this command
//  first_err_addr   out  ADDR_W    address of first mismatching word
//  avm_address      out  ADDR_W    word address
//  avm_byteenable   out  DATA_W/8  constant all ones
//  avm_chipselect   out  1         = avm_read | avm_write
//  avm_read         out  1         read request
//  avm_write        out  1         write request
//  avm_writedata    out  DATA_W    write data
//  avm_readdata     in   DATA_W    read data
//  avm_waitrequest  in   1         slave stall; request held stable while high
//  avm_readdatavalid in  1         readdata valid; returns in issue order
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending=0, counters cleared. Reset mid-command aborts; no done.
//  States: IDLE -> (start, len!=0) FILL|CHECK; IDLE -> (start, len==0) DONE, no bus traffic.
//   FILL: issue len writes; advance when !avm_waitrequest; last accepted write -> DONE.
//   CHECK: issue len reads; last accepted read -> DRAIN; DRAIN: pending==0 -> DONE.
//   DONE: done=1 one cycle, busy=0 -> IDLE. Start accepted the cycle after DONE.
//  Start: clears err_count, first_err_valid; latches base/len/seed/mode; busy=1 next cycle.
//  cmd_start while busy or in DONE: ignored.
//  Address: base+index mod 2**ADDR_W (wrap 8191->0). Index issue/compare counters separate.
//  Request stays asserted with stable address/data while avm_waitrequest=1.
//  Reads: issue only when pending<MAX_PENDING; accept+valid same cycle -> pending unchanged.
//   readdatavalid with pending==0: ignored, no compare. First request >=1 cycle after start.
//  Compare: expected word k from pattern restarted at seed for CHECK; mismatch -> err_count+1
//   (saturate); first mismatch latches first_err_addr=base+k, first_err_valid=1.
//  Outputs err_count/first_err_* hold after done until next accepted start.
// CONFIGURATION
//  PLATFORM_MEMTEST_LFSR_EN defined: pattern word k = LFSR state after k steps from seed,
//   32-bit Galois, poly 0x80200003, seed 0 replaced by 1; one step per word.
//  Not defined: pattern word k = seed + k (mod 2**DATA_W). Timing/protocol identical.
// TESTING
//  1 FILL base=0 len=4 seed=0x10, no stall -> writes 0x10..0x13 at 0..3, done once, busy 4+ cyc.
//  2 CHECK same range, latency-1 slave -> err_count=0, first_err_valid=0, <=MAX_PENDING outstanding.
//  3 CHECK after corrupting word 2 to 0 -> err_count=1, first_err_addr=2, first_err_valid=1.
//  4 FILL base=8190 len=4, random waitrequest -> writes at 8190,8191,0,1, request stable when stalled.
//  5 start len=0 -> done 1-2 cycles later, zero avm_read/avm_write; start during busy ignored.
//  6 reset_n low mid-CHECK -> next cycle all outputs 0, pending=0; stray readdatavalid ignored.

Source files
------------

// File: rtl/platform_onchip_memory_tester_if.sv
// Avalon-MM bus between the memory tester (master) and the on-chip memory (slave).
//
// Handshake: a request (avm_read or avm_write) is accepted on a rising clock edge
// where it is asserted and avm_waitrequest is low. While avm_waitrequest is high the
// master holds avm_address, avm_writedata and the request unchanged. Read data is
// qualified by avm_readdatavalid and returns strictly in the order reads were accepted.
interface platform_onchip_memory_tester_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;
    logic                avm_readdatavalid;

    modport master (
        output avm_address, avm_byteenable, avm_chipselect, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_chipselect, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest, avm_readdatavalid
    );
endinterface

// File: rtl/platform_onchip_memory_tester.sv
// On-chip memory self-test / scrub engine (Avalon-MM master).
// FILL writes a generated pattern over [base, base+len) (address wraps at 2**ADDR_W);
// CHECK reads the range back with up to MAX_PENDING reads in flight, compares each
// returned word against the same pattern, counts mismatches (saturating) and records
// the first mismatching address.
// Optional feature macro: PLATFORM_MEMTEST_LFSR_EN selects a 32-bit Galois LFSR
// pattern (poly 0x80200003, seed 0 replaced by 1); otherwise word k = seed + k.
// dbg_state exposes the FSM state encoding for checkers.
module platform_onchip_memory_tester #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4,
    parameter int ERR_W       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_start,
    input  logic                cmd_mode,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic [DATA_W-1:0]   cmd_seed,
    output logic                busy,
    output logic                done,
    output logic [ERR_W-1:0]    err_count,
    output logic                first_err_valid,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [2:0]          dbg_state,
    platform_onchip_memory_tester_if.master avm
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_CHECK = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ERR_W-1:0]  ERR_ONE  = 1;
    localparam logic [3:0]        PEND_ONE = 4'd1;
    localparam logic [3:0]        PEND_MAX = 4'(MAX_PENDING);
`ifdef PLATFORM_MEMTEST_LFSR_EN
    localparam logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'h8020_0003);
`endif

    // First pattern word of a command.
    function automatic logic [DATA_W-1:0] pat_init(input logic [DATA_W-1:0] seed);
`ifdef PLATFORM_MEMTEST_LFSR_EN
        return (seed == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : seed;
`else
        return seed;
`endif
    endfunction

    // Pattern word k+1 from word k.
    function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
`ifdef PLATFORM_MEMTEST_LFSR_EN
        return p[0] ? ((p >> 1) ^ LFSR_POLY) : (p >> 1);
`else
        return p + {{(DATA_W-1){1'b0}}, 1'b1};
`endif
    endfunction

    state_t              state, state_nxt;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     issue_cnt;
    logic [ADDR_W-1:0]   issue_addr;
    logic [DATA_W-1:0]   issue_pat;
    logic [ADDR_W-1:0]   cmp_addr;
    logic [DATA_W-1:0]   cmp_pat;
    logic [3:0]          pending;

    logic                start_acc;
    logic                req_acc;
    logic                rd_acc;
    logic                rsp_acc;
    logic                issue_last;

    // Issue and response qualifiers shared by the FSM and the datapath.
    always_comb begin
        req_acc    = (avm.avm_read | avm.avm_write) & ~avm.avm_waitrequest;
        rd_acc     = avm.avm_read & ~avm.avm_waitrequest;
        // A response with nothing outstanding is stray and is dropped.
        rsp_acc    = avm.avm_readdatavalid & (pending != 4'd0);
        issue_last = (issue_cnt == (len_q - CNT_ONE));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt          = state;
        start_acc          = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        avm.avm_read       = 1'b0;
        avm.avm_write      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    start_acc = 1'b1;
                    if (cmd_len == '0)  state_nxt = S_DONE;
                    else if (cmd_mode)  state_nxt = S_CHECK;
                    else                state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                busy          = 1'b1;
                avm.avm_write = 1'b1;
                if (req_acc && issue_last) state_nxt = S_DONE;
            end
            S_CHECK: begin
                busy = 1'b1;
                // Once a read is presented pending cannot grow until it is accepted,
                // so the request stays asserted through any stall.
                avm.avm_read = (pending < PEND_MAX);
                if (req_acc && issue_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (pending == 4'd0) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus data outputs come straight from registers that only move on acceptance.
    always_comb begin
        avm.avm_chipselect = avm.avm_read | avm.avm_write;
        avm.avm_byteenable = '1;
        avm.avm_address    = (avm.avm_read | avm.avm_write) ? issue_addr : '0;
        avm.avm_writedata  = avm.avm_write ? issue_pat : '0;
    end

    assign dbg_state = state;

    // Command latch, issue/compare counters, pending reads and error capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_q           <= '0;
            issue_cnt       <= '0;
            issue_addr      <= '0;
            issue_pat       <= '0;
            cmp_addr        <= '0;
            cmp_pat         <= '0;
            pending         <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            if (start_acc) begin
                len_q           <= cmd_len;
                issue_cnt       <= '0;
                issue_addr      <= cmd_base;
                issue_pat       <= pat_init(cmd_seed);
                cmp_addr        <= cmd_base;
                cmp_pat         <= pat_init(cmd_seed);
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
            end else begin
                if (req_acc) begin
                    issue_cnt  <= issue_cnt + CNT_ONE;
                    issue_addr <= issue_addr + ADDR_ONE;
                    issue_pat  <= pat_next(issue_pat);
                end
                if (rsp_acc) begin
                    cmp_addr <= cmp_addr + ADDR_ONE;
                    cmp_pat  <= pat_next(cmp_pat);
                    if (avm.avm_readdata != cmp_pat) begin
                        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_ONE;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_addr  <= cmp_addr;
                        end
                    end
                end
            end
            case ({rd_acc, rsp_acc})
                2'b10:   pending <= pending + PEND_ONE;
                2'b01:   pending <= pending - PEND_ONE;
                default: pending <= pending;
            endcase
        end
    end

endmodule

// File: tb/tb_platform_onchip_memory_tester.sv
// Bench for platform_onchip_memory_tester: a behavioural Avalon-MM memory slave with
// random stalls and random in-order read latency, a reference model that derives
// expected writes, read addresses and CHECK results from the pattern rule, and
// monitors that pop the expected queues whenever the DUT presents bus or done events.
`timescale 1ns/1ps
module tb_platform_onchip_memory_tester;

    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 32;
    localparam int MAX_PENDING = 4;
    localparam int ERR_W       = 16;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int DW          = ERR_W + 1 + ADDR_W;

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                cmd_start = 1'b0;
    logic                cmd_mode = 1'b0;
    logic [ADDR_W-1:0]   cmd_base = '0;
    logic [ADDR_W:0]     cmd_len = '0;
    logic [DATA_W-1:0]   cmd_seed = '0;
    logic                busy, done, first_err_valid;
    logic [ERR_W-1:0]    err_count;
    logic [ADDR_W-1:0]   first_err_addr;
    logic [2:0]          dbg_state;

    platform_onchip_memory_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm_if ();

    platform_onchip_memory_tester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_base(cmd_base),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
        .dbg_state(dbg_state), .avm(avm_if.master)
    );

    always #5 clk = ~clk;

    int pcyc = 0;
    always @(posedge clk) pcyc++;

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0]        mem       [DEPTH];
    logic [DATA_W-1:0]        model_mem [DEPTH];
    logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
    logic [ADDR_W-1:0]        exp_rd_q[$];
    logic [DW-1:0]            exp_done_q[$];

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;
    rsp_t rsp_q[$];

    int checks = 0, errors = 0;
    int cmd_cnt = 0, done_cnt = 0, done_pc = 0, start_pc = 0;
    int busy_cyc = 0, req_cyc = 0, out_cnt = 0, max_out = 0, scyc = 0;
    int stall_pct = 0, lat_min = 1, lat_max = 1;
    bit stray = 1'b0;
    bit held = 1'b0;
    logic [ADDR_W+DATA_W+1:0] held_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference pattern word k for a seed, straight from the pattern rule.
    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] seed, input int k);
`ifdef PLATFORM_MEMTEST_LFSR_EN
        logic [DATA_W-1:0] s;
        s = (seed == 0) ? 32'd1 : seed;
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        return s;
`else
        return seed + DATA_W'(k);
`endif
    endfunction

    // ---------------- memory slave + bus monitor ----------------
    always @(negedge clk) begin
        scyc++;
        if (!reset_n) begin
            rsp_q.delete();
            out_cnt = 0;
            held = 1'b0;
            avm_if.avm_readdatavalid = 1'b0;
            avm_if.avm_waitrequest = 1'b0;
            avm_if.avm_readdata = '0;
        end else begin
            avm_if.avm_readdatavalid = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= scyc) begin
                avm_if.avm_readdatavalid = 1'b1;
                avm_if.avm_readdata = rsp_q[0].data;
                void'(rsp_q.pop_front());
                out_cnt--;
            end else if (stray && rsp_q.size() == 0 && out_cnt == 0) begin
                avm_if.avm_readdatavalid = 1'b1;
                avm_if.avm_readdata = $urandom;
                stray = 1'b0;
            end
            if (held)
                check("req_stable_in_stall",
                      64'({avm_if.avm_read, avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata}),
                      64'(held_req));
            if (avm_if.avm_read || avm_if.avm_write) req_cyc++;
            avm_if.avm_waitrequest = ($urandom_range(99) < stall_pct);
            held = (avm_if.avm_read || avm_if.avm_write) && avm_if.avm_waitrequest;
            held_req = {avm_if.avm_read, avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata};
            if ((avm_if.avm_read || avm_if.avm_write) && !avm_if.avm_waitrequest)
                check("cs_byteenable", 64'({avm_if.avm_chipselect, avm_if.avm_byteenable}), 64'({1'b1, 4'hF}));
            if (avm_if.avm_write && !avm_if.avm_waitrequest) begin
                mem[avm_if.avm_address] = avm_if.avm_writedata;
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             avm_if.avm_address, avm_if.avm_writedata);
                end else begin
                    check("write_addr_data", 64'({avm_if.avm_address, avm_if.avm_writedata}),
                          64'(exp_wr_q.pop_front()));
                end
            end
            if (avm_if.avm_read && !avm_if.avm_waitrequest) begin
                rsp_t r;
                r.data = mem[avm_if.avm_address];
                r.due  = scyc + $urandom_range(lat_min, lat_max);
                rsp_q.push_back(r);
                out_cnt++;
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr 0x%0h, expected no read", avm_if.avm_address);
                end else begin
                    check("read_addr", 64'(avm_if.avm_address), 64'(exp_rd_q.pop_front()));
                end
            end
            if (out_cnt > max_out) max_out = out_cnt;
        end
    end

    // ---------------- done / result monitor ----------------
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (reset_n && done) begin
            logic [DW-1:0] e;
            done_cnt++;
            done_pc = pcyc;
            if (exp_done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1, expected no done");
            end else begin
                e = exp_done_q.pop_front();
                check("err_count", 64'(err_count), 64'(e[DW-1 -: ERR_W]));
                check("first_err_valid", 64'(first_err_valid), 64'(e[ADDR_W]));
                if (e[ADDR_W]) check("first_err_addr", 64'(first_err_addr), 64'(e[ADDR_W-1:0]));
            end
        end
    end

    // ---------------- reference model + driver tasks ----------------
    task automatic model_cmd(input bit mode, input int base, input int len, input logic [DATA_W-1:0] seed);
        int errs = 0;
        int first = -1;
        for (int k = 0; k < len; k++) begin
            int a = (base + k) % DEPTH;
            if (!mode) begin
                exp_wr_q.push_back({ADDR_W'(a), pat(seed, k)});
                model_mem[a] = pat(seed, k);
            end else begin
                exp_rd_q.push_back(ADDR_W'(a));
                if (model_mem[a] !== pat(seed, k)) begin
                    errs++;
                    if (first < 0) first = a;
                end
            end
        end
        exp_done_q.push_back({ERR_W'(errs), (first >= 0), ADDR_W'((first >= 0) ? first : 0)});
        cmd_cnt++;
    endtask

    task automatic run_cmd(input bit mode, input int base, input int len, input logic [DATA_W-1:0] seed);
        model_cmd(mode, base, len, seed);
        @(negedge clk);
        cmd_mode = mode; cmd_base = ADDR_W'(base); cmd_len = (ADDR_W+1)'(len); cmd_seed = seed;
        cmd_start = 1'b1; start_pc = pcyc;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt < cmd_cnt && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < cmd_cnt) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d done pulses, expected %0d", name, done_cnt, cmd_cnt);
            done_cnt = cmd_cnt;
        end
    endtask

    task automatic corrupt(input int a, input logic [DATA_W-1:0] v);
        mem[a % DEPTH] = v;
        model_mem[a % DEPTH] = v;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base, len, req0;
        logic [DATA_W-1:0] seed;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DATA_W-1:0] v = $urandom;
            mem[i] = v;
            model_mem[i] = v;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_status", 64'({busy, done, err_count, first_err_valid, first_err_addr, dbg_state}), 64'(0));
        check("reset_bus", 64'({avm_if.avm_read, avm_if.avm_write, avm_if.avm_chipselect,
                               avm_if.avm_address, avm_if.avm_writedata}), 64'(0));
        reset_n = 1'b1;

        // FILL base 0 len 4 seed 0x10, no stalls.
        busy_cyc = 0;
        run_cmd(1'b0, 0, 4, 32'h10);
        wait_done("fill_basic");
        check("fill_busy_ge4", 64'(busy_cyc >= 4), 64'(1));
        for (int k = 0; k < 4; k++) check("fill_mem_word", 64'(mem[k]), 64'(pat(32'h10, k)));

        // CHECK same range, latency-1 slave.
        run_cmd(1'b1, 0, 4, 32'h10);
        wait_done("check_clean");

        // CHECK after corrupting word 2.
        corrupt(2, 32'h0);
        run_cmd(1'b1, 0, 4, 32'h10);
        wait_done("check_corrupt");

        // Long read latency drives outstanding reads to the limit.
        run_cmd(1'b0, 100, 16, 32'h55);
        wait_done("fill_pend");
        lat_min = 6; lat_max = 6;
        run_cmd(1'b1, 100, 16, 32'h55);
        wait_done("check_pend");
        check("outstanding_limit_reached", 64'(max_out), 64'(MAX_PENDING));

        // FILL across the top of memory with random stalls, then CHECK it back.
        stall_pct = 50; lat_min = 1; lat_max = 4;
        run_cmd(1'b0, DEPTH - 2, 4, 32'hCAFE_0000);
        wait_done("fill_wrap");
        stall_pct = 30;
        run_cmd(1'b1, DEPTH - 2, 4, 32'hCAFE_0000);
        wait_done("check_wrap");

        // len=0: done with no traffic; a start held into the DONE cycle is ignored.
        stall_pct = 0;
        req0 = req_cyc;
        model_cmd(1'b1, 50, 0, 32'h0);
        @(negedge clk);
        cmd_mode = 1'b1; cmd_base = 13'd50; cmd_len = '0; cmd_start = 1'b1; start_pc = pcyc;
        @(negedge clk);
        cmd_mode = 1'b0; cmd_base = 13'd900; cmd_len = 14'd3;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done("len0");
        repeat (6) @(negedge clk);
        check("len0_done_latency_1to2", 64'((done_pc - start_pc >= 1) && (done_pc - start_pc <= 2)), 64'(1));
        check("len0_no_traffic", 64'(req_cyc - req0), 64'(0));
        check("start_in_done_ignored", 64'(done_cnt), 64'(cmd_cnt));

        // Start while busy is ignored.
        stall_pct = 50;
        run_cmd(1'b0, 300, 8, 32'hA5A5_0000);
        @(negedge clk);
        check("busy_during_fill", 64'(busy), 64'(1));
        cmd_mode = 1'b1; cmd_base = 13'd700; cmd_len = 14'd1; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done("fill_busy_start");
        repeat (6) @(negedge clk);
        check("start_while_busy_ignored", 64'(done_cnt), 64'(cmd_cnt));

        // Randomized FILL/CHECK pairs with occasional corruption or wrong seed.
        for (int it = 0; it < 10; it++) begin
            stall_pct = $urandom_range(0, 60);
            lat_min = 1; lat_max = $urandom_range(1, 5);
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 40);
            seed = $urandom;
            run_cmd(1'b0, base, len, seed);
            wait_done("rand_fill");
            for (int j = 0; j < $urandom_range(0, 3); j++)
                corrupt(base + $urandom_range(0, len - 1), $urandom);
            run_cmd(1'b1, base, len, ($urandom_range(0, 3) == 0) ? (seed ^ 32'h1) : seed);
            wait_done("rand_check");
        end
        // CHECK over never-filled memory: many mismatches.
        run_cmd(1'b1, 4000, 25, 32'h0);
        wait_done("check_unfilled");

        // Reset in the middle of a CHECK.
        stall_pct = 20; lat_min = 2; lat_max = 4;
        run_cmd(1'b1, 1000, 30, 32'h1234);
        repeat (8) @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'(1));
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_status", 64'({busy, done, err_count, first_err_valid, first_err_addr, dbg_state}), 64'(0));
        check("midreset_bus", 64'({avm_if.avm_read, avm_if.avm_write, avm_if.avm_chipselect,
                                  avm_if.avm_address, avm_if.avm_writedata}), 64'(0));
        exp_wr_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cmd_cnt = done_cnt;
        stray = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(cmd_cnt));
        check("stray_valid_no_compare", 64'({err_count, first_err_valid}), 64'(0));
        check("stray_valid_no_traffic", 64'({avm_if.avm_read, avm_if.avm_write}), 64'(0));

        // Full CHECK after the abort.
        run_cmd(1'b1, 1000, 30, 32'h1234);
        wait_done("check_after_reset");
        stall_pct = 0; lat_min = 1; lat_max = 1;
        run_cmd(1'b0, 1000, 30, 32'h1234);
        wait_done("fill_after_reset");
        run_cmd(1'b1, 1000, 30, 32'h1234);
        wait_done("check_after_reset_fill");

        repeat (4) @(negedge clk);
        check("exp_queues_empty", 64'(exp_wr_q.size() + exp_rd_q.size() + exp_done_q.size()), 64'(0));
        check("outstanding_never_over", 64'(max_out <= MAX_PENDING), 64'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
